// File: rtl/mem_arbiter_if.sv
// Cache-line memory port: read/write request with address and write data towards
// the target, one-cycle completion pulse and read data back to the initiator.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 128
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  resp;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output read, write, address, wdata,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata,
    output resp, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin merge of the I-fetch and data cache ports onto one single-port memory;
// each request is latched at grant and served to completion before the next grant.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  cache_i,
  mem_arbiter_if.slave  cache_d,
  mem_arbiter_if.master pmem
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_I  = 2'd1,
    SERVE_D  = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  state_e                state_q, state_d;
  side_e                 last_grant_q, last_grant_d;
  logic                  lat_read_q, lat_read_d;
  logic                  lat_write_q, lat_write_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_hold_i_q, rdata_hold_i_d;
  logic [DATA_WIDTH-1:0] rdata_hold_d_q, rdata_hold_d_d;

  logic req_i, req_d;
  logic grant_i, grant_d;
  logic serving;
  logic resp_i, resp_d;

  assign req_i = cache_i.read | cache_i.write;
  assign req_d = cache_d.read | cache_d.write;

  // On a tie the side that did not win the previous grant goes first.
  assign grant_i = req_i & (~req_d | (last_grant_q == SIDE_D));
  assign grant_d = req_d & ~grant_i;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    lat_read_d     = lat_read_q;
    lat_write_d    = lat_write_q;
    lat_addr_d     = lat_addr_q;
    lat_wdata_d    = lat_wdata_q;
    rdata_hold_i_d = rdata_hold_i_q;
    rdata_hold_d_d = rdata_hold_d_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = SIDE_I;
          lat_write_d  = cache_i.write;
          lat_read_d   = cache_i.read & ~cache_i.write;
          lat_addr_d   = cache_i.address;
          lat_wdata_d  = cache_i.wdata;
        end else if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = SIDE_D;
          lat_write_d  = cache_d.write;
          lat_read_d   = cache_d.read & ~cache_d.write;
          lat_addr_d   = cache_d.address;
          lat_wdata_d  = cache_d.wdata;
        end
      end
      SERVE_I: begin
        if (pmem.resp) begin
          state_d        = COOLDOWN;
          rdata_hold_i_d = pmem.rdata;
        end
      end
      SERVE_D: begin
        if (pmem.resp) begin
          state_d        = COOLDOWN;
          rdata_hold_d_d = pmem.rdata;
        end
      end
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= SIDE_D;
      lat_read_q     <= 1'b0;
      lat_write_q    <= 1'b0;
      lat_addr_q     <= '0;
      lat_wdata_q    <= '0;
      rdata_hold_i_q <= '0;
      rdata_hold_d_q <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      lat_read_q     <= lat_read_d;
      lat_write_q    <= lat_write_d;
      lat_addr_q     <= lat_addr_d;
      lat_wdata_q    <= lat_wdata_d;
      rdata_hold_i_q <= rdata_hold_i_d;
      rdata_hold_d_q <= rdata_hold_d_d;
    end
  end

  assign serving = (state_q == SERVE_I) | (state_q == SERVE_D);

  assign pmem.write   = serving & lat_write_q;
  assign pmem.read    = serving & lat_read_q & ~lat_write_q;
  assign pmem.address = lat_addr_q;
  assign pmem.wdata   = lat_wdata_q;

  // Gated by rst_n so a completion that lands while reset is asserted is dropped.
  assign resp_i = rst_n & (state_q == SERVE_I) & pmem.resp;
  assign resp_d = rst_n & (state_q == SERVE_D) & pmem.resp;

  assign cache_i.resp  = resp_i;
  assign cache_d.resp  = resp_d;
  assign cache_i.rdata = resp_i ? pmem.rdata : rdata_hold_i_q;
  assign cache_d.rdata = resp_d ? pmem.rdata : rdata_hold_d_q;

  a_resp_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(resp_i && resp_d));
  a_pmem_op_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(pmem.read && pmem.write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed protocol scenarios plus randomized I/D traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 128;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc_i ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc_d ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc_m ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cache_i (ifc_i),
    .cache_d (ifc_d),
    .pmem    (ifc_m)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] mem     [4096];
  logic [DW-1:0] ref_mem [4096];
  bit            spur_req = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 255));
    return a;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- memory model: response 3 cycles after the request ----------------
  initial begin
    bit            act, op_w, was_resp;
    int            cnt;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    ifc_m.resp  = 1'b0;
    ifc_m.rdata = '0;
    was_resp = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      act  = ifc_m.read | ifc_m.write;
      op_w = ifc_m.write;
      a    = ifc_m.address;
      wd   = ifc_m.wdata;
      @(posedge clk);
      #1;
      ifc_m.resp  = 1'b0;
      ifc_m.rdata = rand_data();
      if (was_resp) begin
        was_resp = 1'b0;
        cnt = 0;
      end else if (!act) begin
        cnt = 0;
        if (spur_req) begin
          spur_req   = 1'b0;
          ifc_m.resp = 1'b1;
        end
      end else begin
        cnt++;
        if (cnt == 3) begin
          cnt        = 0;
          was_resp   = 1'b1;
          ifc_m.resp = 1'b1;
          if (op_w) mem[a[AW-1:4]] = wd;
          else ifc_m.rdata = mem[a[AW-1:4]];
        end
      end
    end
  end

  // ---------------- reference model (owner 0 none, 1 I-side, 2 D-side) ----------------
  bit            model_valid = 1'b0;
  int            m_owner, m_last;
  bit            m_cool, m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_held_i, m_held_d;

  initial begin
    bit ri, rd;
    int pick;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_valid = 1'b1;
        m_owner = 0; m_cool = 1'b0; m_last = 2;
        m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        m_held_i = '0; m_held_d = '0;
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (m_owner != 0) begin
        if (ifc_m.resp) begin
          if (m_owner == 1) m_held_i = ifc_m.rdata;
          else m_held_d = ifc_m.rdata;
          if (m_wr) ref_mem[m_addr[AW-1:4]] = m_wdata;
          m_owner = 0;
          m_cool  = 1'b1;
        end
      end else begin
        ri = ifc_i.read | ifc_i.write;
        rd = ifc_d.read | ifc_d.write;
        if (ri && rd) pick = (m_last == 1) ? 2 : 1;
        else if (ri) pick = 1;
        else if (rd) pick = 2;
        else pick = 0;
        if (pick == 1) begin
          m_wr = ifc_i.write; m_rd = ifc_i.read; m_addr = ifc_i.address; m_wdata = ifc_i.wdata;
        end else if (pick == 2) begin
          m_wr = ifc_d.write; m_rd = ifc_d.read; m_addr = ifc_d.address; m_wdata = ifc_d.wdata;
        end
        if (pick != 0) begin
          m_owner = pick;
          m_last  = pick;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    bit e_srv, e_pr, e_pw, e_ri, e_rd;
    forever begin
      @(negedge clk);
      if (model_valid) begin
        e_srv = (m_owner != 0);
        e_pw  = e_srv && m_wr;
        e_pr  = e_srv && m_rd && !m_wr;
        e_ri  = rst_n && (m_owner == 1) && ifc_m.resp;
        e_rd  = rst_n && (m_owner == 2) && ifc_m.resp;
        chk("pmem_read", DW'(ifc_m.read), DW'(e_pr));
        chk("pmem_write", DW'(ifc_m.write), DW'(e_pw));
        if (e_srv) chk("pmem_address", DW'(ifc_m.address), DW'(m_addr));
        if (e_pw) chk("pmem_wdata", ifc_m.wdata, m_wdata);
        chk("resp_i", DW'(ifc_i.resp), DW'(e_ri));
        chk("resp_d", DW'(ifc_d.resp), DW'(e_rd));
        chk("rdata_i", ifc_i.rdata, e_ri ? ifc_m.rdata : m_held_i);
        chk("rdata_d", ifc_d.rdata, e_rd ? ifc_m.rdata : m_held_d);
        if (e_ri && !m_wr) chk("rdata_i_vs_mem", ifc_i.rdata, ref_mem[m_addr[AW-1:4]]);
        if (e_rd && !m_wr) chk("rdata_d_vs_mem", ifc_d.rdata, ref_mem[m_addr[AW-1:4]]);
      end
    end
  end

  // ---------------- requester helpers ----------------
  task automatic set_req(input int side, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (side == 1) begin
      ifc_i.read = rd; ifc_i.write = wr; ifc_i.address = a; ifc_i.wdata = wd;
    end else begin
      ifc_d.read = rd; ifc_d.write = wr; ifc_d.address = a; ifc_d.wdata = wd;
    end
  endtask

  task automatic drop(input int side);
    if (side == 1) begin
      ifc_i.read = 1'b0; ifc_i.write = 1'b0;
    end else begin
      ifc_d.read = 1'b0; ifc_d.write = 1'b0;
    end
  endtask

  task automatic wiggle(input int side);
    if (side == 1) begin
      ifc_i.address = rand_addr(); ifc_i.wdata = rand_data();
    end else begin
      ifc_d.address = rand_addr(); ifc_d.wdata = rand_data();
    end
  endtask

  task automatic wait_resp(input int side, input bit do_wiggle, output logic [DW-1:0] data);
    bit   seen;
    logic r;
    seen = 1'b0;
    data = '0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      r = (side == 1) ? ifc_i.resp : ifc_d.resp;
      if (r) begin
        seen = 1'b1;
        data = (side == 1) ? ifc_i.rdata : ifc_d.rdata;
      end else if (do_wiggle && $urandom_range(0, 3) == 0) begin
        wiggle(side);
      end
    end
    chk("resp_timeout", DW'(seen), DW'(1));
  endtask

  task automatic finish_txn(input int side, output logic [DW-1:0] data);
    wait_resp(side, 1'b0, data);
    @(posedge clk); #1;
    drop(side);
    @(posedge clk); #1;
  endtask

  task automatic rand_requester(input int side, input int n);
    logic [DW-1:0] data;
    int            op;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(1, 4)) begin
        @(posedge clk); #1;
      end
      op = $urandom_range(0, 2);
      set_req(side, op != 1, op != 0, rand_addr(), rand_data());
      wait_resp(side, 1'b1, data);
      @(posedge clk); #1;
      drop(side);
    end
  endtask

  // ---------------- directed scenarios then random traffic ----------------
  initial begin
    logic [DW-1:0] data;
    int            order[$];
    int            gaps[$];
    int            low, cnt;
    bit            counting;
    int            rr_exp[4] = '{1, 2, 1, 2};

    for (int k = 0; k < 4096; k++) begin
      mem[k] = '0;
      ref_mem[k] = '0;
    end
    mem[1] = {8{16'hAAAA}}; ref_mem[1] = {8{16'hAAAA}};
    mem[3] = {8{16'h5A5A}}; ref_mem[3] = {8{16'h5A5A}};

    rst_n = 1'b0;
    set_req(1, 1'b1, 1'b0, 16'h0010, '0);
    set_req(2, 1'b1, 1'b0, 16'h0030, '0);

    // Reset held with both sides requesting.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pmem_read", DW'(ifc_m.read), DW'(0));
    chk("rst_pmem_write", DW'(ifc_m.write), DW'(0));
    chk("rst_pmem_address", DW'(ifc_m.address), DW'(0));
    chk("rst_pmem_wdata", ifc_m.wdata, DW'(0));
    chk("rst_resp_i", DW'(ifc_i.resp), DW'(0));
    chk("rst_resp_d", DW'(ifc_d.resp), DW'(0));
    chk("rst_rdata_i", ifc_i.rdata, DW'(0));
    chk("rst_rdata_d", ifc_d.rdata, DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First tie goes to I.
    @(negedge clk);
    @(negedge clk);
    chk("tie_pmem_read", DW'(ifc_m.read), DW'(1));
    chk("tie_pmem_address", DW'(ifc_m.address), DW'(16'h0010));
    wait_resp(1, 1'b0, data);
    chk("i_read_data", data, {8{16'hAAAA}});
    chk("i_read_resp_d", DW'(ifc_d.resp), DW'(0));
    @(posedge clk); #1;
    drop(1);
    finish_txn(2, data);
    chk("d_read_data", data, {8{16'h5A5A}});

    // D-side write then I-side read-back of the same line.
    set_req(2, 1'b0, 1'b1, 16'h0020, {8{16'h1234}});
    @(negedge clk);
    @(negedge clk);
    chk("d_write_pmem_write", DW'(ifc_m.write), DW'(1));
    chk("d_write_pmem_read", DW'(ifc_m.read), DW'(0));
    chk("d_write_pmem_wdata", ifc_m.wdata, {8{16'h1234}});
    finish_txn(2, data);
    set_req(1, 1'b1, 1'b0, 16'h0020, '0);
    finish_txn(1, data);
    chk("readback_data", data, {8{16'h1234}});

    // Stray memory completion while idle.
    spur_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("spur_resp_i", DW'(ifc_i.resp), DW'(0));
      chk("spur_resp_d", DW'(ifc_d.resp), DW'(0));
      chk("spur_rdata_i_hold", ifc_i.rdata, {8{16'h1234}});
    end
    @(posedge clk); #1;

    // Requester inputs change while being served.
    set_req(2, 1'b1, 1'b0, 16'h0040, '0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(2, 1'b0, 1'b0, 16'h0FF0, '0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ifc_m.read) chk("mid_pmem_address", DW'(ifc_m.address), DW'(16'h0040));
      if (ifc_d.resp) cnt++;
    end
    chk("mid_resp_d_pulses", DW'(cnt), DW'(1));
    @(posedge clk); #1;

    // Both sides held high: alternate grants, two low cycles between transactions.
    set_req(1, 1'b1, 1'b0, 16'h0010, '0);
    set_req(2, 1'b1, 1'b0, 16'h0020, '0);
    low = 0;
    counting = 1'b0;
    for (int k = 0; k < 120 && order.size() < 4; k++) begin
      @(negedge clk);
      if (ifc_i.resp) order.push_back(1);
      if (ifc_d.resp) order.push_back(2);
      if (ifc_i.resp || ifc_d.resp) begin
        counting = 1'b1;
        low = 0;
      end else if (counting) begin
        if (!ifc_m.read) low++;
        else begin
          gaps.push_back(low);
          counting = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    drop(1);
    drop(2);
    @(posedge clk); #1;
    chk("rr_count", DW'(order.size()), DW'(4));
    for (int k = 0; k < 4; k++)
      chk("rr_order", DW'((k < order.size()) ? order[k] : 0), DW'(rr_exp[k]));
    chk("rr_gap_count", DW'(gaps.size()), DW'(3));
    for (int k = 0; k < gaps.size(); k++) chk("rr_gap_len", DW'(gaps[k]), DW'(2));

    // Reset while I is being served; the memory completion then arrives during reset.
    set_req(1, 1'b1, 1'b0, 16'h0050, '0);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_pmem_read_before", DW'(ifc_m.read), DW'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    drop(1);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_pmem_read_after", DW'(ifc_m.read), DW'(0));
    chk("rstmid_resp_i", DW'(ifc_i.resp), DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ifc_i.resp) cnt++;
    end
    chk("rstmid_no_resp_i", DW'(cnt), DW'(0));
    @(posedge clk); #1;

    fork
      rand_requester(1, 30);
      rand_requester(2, 30);
    join

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required completion earlier", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
